integer_to_floating_point_converter: RTL and testbench
======================================================

// Module: integer_to_floating_point_converter
// PURPOSE
// - Iterative 32-bit integer -> IEEE-754 single-precision converter; the producer side that feeds float operands to the adder datapath.
// - Accepts a signed or unsigned integer over a valid/ready handshake.
// - Normalises it with a one-bit-per-cycle shift FSM, rounds, and presents the packed float over a valid/ready handshake.
// PARAMETERS
// - DATA_WIDTH  32  float word width {sign,exponent,mentissa}
// - INT_WIDTH   32  integer input width; must be > MENT_WIDTH+1
// - MENT_WIDTH  23  stored mentissa bits
// - EXPO_WIDTH  8   exponent bits
// - EXPO_BIAS   127 exponent bias
// PORTS
// - clk_in         in   1           single clock; all state changes on rising edge
// - reset_in       in   1           synchronous, active-high reset
// - integer_in     in   INT_WIDTH   integer operand
// - signed_in      in   1           1: integer_in is two's complement; 0: unsigned
// - valid_in       in   1           integer_in/signed_in valid
// - ready_out      out  1           converter can accept (high only in IDLE)
// - floating_out   out  DATA_WIDTH  packed result, stable while valid_out=1
// - valid_out      out  1           result valid
// - ready_in       in   1           downstream accepts result
// - inexact_out    out  1           discarded nonzero bits (guard|sticky), qualified by valid_out
// BEHAVIOUR
// - Reset: state=IDLE; ready_out=0 during the reset cycle and 1 after it; valid_out=0; floating_out=0; inexact_out=0.
//   Reset mid-conversion aborts it; the in-flight operand is discarded.
// - IDLE: on valid_in&ready_out, capture sign = signed_in & integer_in[MSB], mag = |integer_in|, exp = EXPO_BIAS+INT_WIDTH-1.
//   - mag==0: next state is DONE with result +0.
//   - Otherwise: next state is NORM.
//   - Most-negative signed input: mag = 2^(INT_WIDTH-1), no overflow.
// - NORM: if mag[INT_WIDTH-1]=1, go to RND; else mag<<=1 and exp-=1, stay.
// - RND: m = mag[INT_WIDTH-2 -: MENT_WIDTH]; guard = next bit below; sticky = OR of the rest.
//   Apply rounding, register the result, go to DONE.
//   - Mentissa carry-out: mentissa = 0, exp += 1. No overflow is possible for INT_WIDTH <= 128.
// - DONE: valid_out=1; floating_out and inexact_out hold until ready_in=1. On the handshake edge go to IDLE.
//   ready_out rises in the following cycle; no back-to-back accept in the same edge.
// - Latency: accept edge to valid_out = lz+3 edges (lz = leading zeros of mag); zero input = 1 edge.
//   Worst case (mag=1) is INT_WIDTH+2.
// - valid_in while busy is ignored (ready_out=0); the source must hold it.
// - Output never negative zero; result is exact whenever mag < 2^(MENT_WIDTH+1).
// CONFIGURATION
// - Macro FP_CONVERT_ROUND_NEAREST_EVEN_EN.
//   - Defined: round to nearest, ties to even; increment m when guard & (sticky | m[0]).
//   - Undefined: truncate toward zero, no increment.
// - inexact_out is reported identically in both builds.
// STRUCTURE
// - Shared package fp_pkg holds:
//   - width/bias constants (DATA_WIDTH, MENT_WIDTH, EXPO_WIDTH, EXPO_BIAS)
//   - 2-bit state enum {IDLE, NORM, RND, DONE}
//   - float field typedef {sign, exponent, mentissa}
// - One combinational sub-module, fp_mentissa_rounder: takes m, guard, sticky; returns rounded m, carry, inexact.
//   Holds the macro-dependent logic so the adder's rounding stage can reuse it.
// TESTING
// - signed 0x00000001 -> 0x3F800000, inexact 0, valid_out 34 edges after accept.
// - signed 0xFFFFFFFF (-1) -> 0xBF800000; unsigned 0xFFFFFFFF -> 0x4F800000 with RNE (0x4F7FFFFF truncate), inexact 1.
// - 0x00000000 -> 0x00000000 after 1 edge; signed 0x80000000 -> 0xCF000000, inexact 0.
// - unsigned 0x01000003 -> 0x4B800002 RNE / 0x4B800001 truncate, inexact 1; 0x01000001 -> 0x4B800000 both builds.
// - Hold ready_in=0 for 10 cycles in DONE: floating_out stable, valid_out high, ready_out low, new valid_in ignored.
// - Assert reset_in during NORM: next cycle valid_out=0, outputs 0; then a fresh 0x00000002 converts to 0x40000000.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared float-format constants, converter state encoding and the
//            packed float field layout used by the float datapath blocks.
// Config   : FP_CONVERT_ROUND_NEAREST_EVEN_EN (consumed by fp_mentissa_rounder)
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MENT_WIDTH = 23;
    localparam int EXPO_WIDTH = 8;
    localparam int EXPO_BIAS  = 127;

    // Converter sequencing: capture, normalise one bit per cycle, round, present
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Packed single-precision word as it travels between blocks
    typedef struct packed {
        logic                  sign;
        logic [EXPO_WIDTH-1:0] exponent;
        logic [MENT_WIDTH-1:0] mentissa;
    } float_t;

endpackage
`default_nettype wire

// File: rtl/fp_mentissa_rounder.sv
`default_nettype none
// ============================================================================
// Module   : fp_mentissa_rounder
// Brief    : Combinational mentissa rounding step shared by the converter and
//            the adder. Takes the kept mentissa bits plus guard/sticky and
//            returns the rounded mentissa, its carry-out and the inexact flag.
// Config   : FP_CONVERT_ROUND_NEAREST_EVEN_EN defined -> round to nearest,
//            ties to even; undefined -> truncate toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mentissa_rounder #(
    parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH
) (
    input  logic [MENT_WIDTH-1:0] i_mentissa,
    input  logic                  i_guard,
    input  logic                  i_sticky,
    output logic [MENT_WIDTH-1:0] o_mentissa,
    output logic                  o_carry,
    output logic                  o_inexact
);

    // Any discarded nonzero bit makes the result inexact, whatever the mode
    assign o_inexact = i_guard | i_sticky;

`ifdef FP_CONVERT_ROUND_NEAREST_EVEN_EN
    logic w_increment;

    // Round up above half, or exactly at half when the kept LSB is odd
    assign w_increment = i_guard & (i_sticky | i_mentissa[0]);
    assign {o_carry, o_mentissa} = {1'b0, i_mentissa} + {{MENT_WIDTH{1'b0}}, w_increment};
`else
    // Truncation simply drops the discarded bits
    assign o_mentissa = i_mentissa;
    assign o_carry    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/integer_to_floating_point_converter.sv
`default_nettype none
// ============================================================================
// Module   : integer_to_floating_point_converter
// Brief    : Iterative signed/unsigned integer to IEEE-754 single-precision
//            converter. Captures magnitude over valid/ready, normalises one bit
//            per cycle, rounds once, then holds the packed float until taken.
// Config   : FP_CONVERT_ROUND_NEAREST_EVEN_EN selects RNE over truncation
//            (handled inside fp_mentissa_rounder).
// Revision : 1.0 - initial release
// ============================================================================
module integer_to_floating_point_converter #(
    parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
    parameter int INT_WIDTH  = 32,
    parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH,
    parameter int EXPO_WIDTH = fp_pkg::EXPO_WIDTH,
    parameter int EXPO_BIAS  = fp_pkg::EXPO_BIAS
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [INT_WIDTH-1:0]  integer_in,
    input  logic                  signed_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] floating_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  inexact_out
);

    import fp_pkg::*;

    // Bit position of the first discarded bit once the leading one sits at the MSB
    localparam int                     c_guard_idx = INT_WIDTH - 2 - MENT_WIDTH;
    // Exponent of the captured value before any left shift (leading one at MSB)
    localparam logic [EXPO_WIDTH-1:0]  c_start_exp = EXPO_WIDTH'(EXPO_BIAS + INT_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_sign;
    logic [INT_WIDTH-1:0]   r_mag;
    logic [EXPO_WIDTH-1:0]  r_exp;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_inexact;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_in_neg;
    logic [INT_WIDTH-1:0]   w_in_mag;
    logic                   w_in_zero;

    logic [MENT_WIDTH-1:0]  w_ment;
    logic                   w_guard;
    logic                   w_sticky;
    logic [MENT_WIDTH-1:0]  w_ment_rnd;
    logic                   w_carry;
    logic                   w_inexact;
    logic [EXPO_WIDTH-1:0]  w_exp_rnd;

    // Ready is withheld while reset is asserted so nothing is accepted that cycle
    assign w_ready   = (r_state == IDLE) && !reset_in;
    assign w_accept  = valid_in && w_ready;

    // Two's complement magnitude; the most-negative value maps to 2^(INT_WIDTH-1)
    assign w_in_neg  = signed_in & integer_in[INT_WIDTH-1];
    assign w_in_mag  = w_in_neg ? (~integer_in + {{(INT_WIDTH-1){1'b0}}, 1'b1}) : integer_in;
    assign w_in_zero = (w_in_mag == '0);

    // Field extraction from the normalised magnitude (leading one dropped)
    assign w_ment    = r_mag[INT_WIDTH-2 -: MENT_WIDTH];
    assign w_guard   = r_mag[c_guard_idx];
    assign w_sticky  = |r_mag[c_guard_idx-1:0];
    assign w_exp_rnd = r_exp + {{(EXPO_WIDTH-1){1'b0}}, w_carry};

    fp_mentissa_rounder #(
        .MENT_WIDTH (MENT_WIDTH)
    ) u_rounder (
        .i_mentissa (w_ment),
        .i_guard    (w_guard),
        .i_sticky   (w_sticky),
        .o_mentissa (w_ment_rnd),
        .o_carry    (w_carry),
        .o_inexact  (w_inexact)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: zero skips straight to DONE, otherwise shift until MSB set
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = w_in_zero ? DONE : NORM;
            NORM: if (r_mag[INT_WIDTH-1]) w_next_state = RND;
            RND:  w_next_state = DONE;
            DONE: if (ready_in) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: capture operand, normalise, then register the rounded result
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_exp     <= '0;
            r_result  <= '0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_in_neg;
                        r_mag  <= w_in_mag;
                        r_exp  <= c_start_exp;
                        if (w_in_zero) begin
                            r_result  <= '0;
                            r_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[INT_WIDTH-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                RND: begin
                    // On mentissa carry-out the rounded field is already all zeros
                    r_result  <= {r_sign, w_exp_rnd, w_ment_rnd};
                    r_inexact <= w_inexact;
                end
                default: ;
            endcase
        end
    end

    assign ready_out    = w_ready;
    assign valid_out    = (r_state == DONE);
    assign floating_out = r_result;
    assign inexact_out  = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_integer_to_floating_point_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_integer_to_floating_point_converter
// Brief    : Self-checking bench: directed vector table, handshake hold and
//            reset-abort sequences, and randomized operands against an
//            arithmetic reference model.
// Config   : FP_CONVERT_ROUND_NEAREST_EVEN_EN selects expected rounding mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_integer_to_floating_point_converter;

`ifdef FP_CONVERT_ROUND_NEAREST_EVEN_EN
    localparam bit c_rne = 1'b1;
`else
    localparam bit c_rne = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [31:0] integer_in = '0;
    logic        signed_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] floating_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        inexact_out;

    int n_pass  = 0;
    int n_total = 0;

    integer_to_floating_point_converter dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .integer_in   (integer_in),
        .signed_in    (signed_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .floating_out (floating_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .inexact_out  (inexact_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] val;
        logic        sgn;
        logic [31:0] f_rne;
        logic [31:0] f_trn;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference: locate the leading one, scale to 24 significant bits, round the remainder
    function automatic void model(input logic [31:0] v, input logic s,
                                  output logic [31:0] f, output logic inx, output int lat);
        logic neg;
        longint unsigned mag, q, rem, half;
        int p, e, sh;
        neg = s & v[31];
        mag = neg ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        if (mag == 0) begin
            f = '0; inx = 1'b0; lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e = 127 + p;
        if (p <= 23) begin
            q   = mag << (23 - p);
            inx = 1'b0;
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (c_rne && (rem > half || (rem == half && q[0]))) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        f   = {neg, e[7:0], q[22:0]};
        lat = (31 - p) + 3;
    endfunction

    // One full transaction; latency counts edges from the accept edge to valid_out
    task automatic convert(input logic [31:0] v, input logic s,
                           output logic [31:0] f, output logic inx, output int lat);
        int w;
        w = 0;
        while (!ready_out && w < 100) begin tick(); w++; end
        if (!ready_out) check("ready_wait_timeout", 32'd0, 32'd1);
        integer_in = v;
        signed_in  = s;
        valid_in   = 1'b1;
        tick();
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 100) begin tick(); lat++; end
        if (!valid_out) check("valid_wait_timeout", 32'd0, 32'd1);
        f   = floating_out;
        inx = inexact_out;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] f, f0, ef, v;
        logic        inx, einx, s;
        int          lat, elat;

        vecs[0] = '{32'h0000_0001, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 34};
        vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 32'hBF80_0000, 1'b0, 34};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 32'h4F7F_FFFF, 1'b1, 3};
        vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[4] = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 32'hCF00_0000, 1'b0, 3};
        vecs[5] = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 32'h4B80_0001, 1'b1, 10};
        vecs[6] = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 32'h4B80_0000, 1'b1, 10};
        vecs[7] = '{32'h0000_0002, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0, 33};

        // Reset state
        tick();
        tick();
        check("ready_during_reset", {31'd0, ready_out}, 32'd0);
        reset_in = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, ready_out}, 32'd1);
        check("valid_after_reset", {31'd0, valid_out}, 32'd0);
        check("float_after_reset", floating_out, 32'd0);
        check("inexact_after_reset", {31'd0, inexact_out}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].val, vecs[i].sgn, f, inx, lat);
            check($sformatf("vec%0d_result", i), f, c_rne ? vecs[i].f_rne : vecs[i].f_trn);
            check($sformatf("vec%0d_inexact", i), {31'd0, inx}, {31'd0, vecs[i].inx});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Hold in DONE with ready_in low while a new operand is offered
        model(32'h1234_5678, 1'b0, ef, einx, elat);
        integer_in = 32'h1234_5678;
        signed_in  = 1'b0;
        valid_in   = 1'b1;
        tick();
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 100) begin tick(); lat++; end
        check("hold_result", floating_out, ef);
        f0 = floating_out;
        integer_in = 32'hDEAD_BEEF;
        valid_in   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d_float", i), floating_out, f0);
            check($sformatf("hold%0d_valid", i), {31'd0, valid_out}, 32'd1);
            check($sformatf("hold%0d_ready", i), {31'd0, ready_out}, 32'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("post_handshake_valid", {31'd0, valid_out}, 32'd0);
        check("post_handshake_ready", {31'd0, ready_out}, 32'd1);
        tick();
        tick();
        check("ignored_input_no_result", {31'd0, valid_out}, 32'd0);

        // Reset while normalising aborts the conversion
        integer_in = 32'h0000_0001;
        signed_in  = 1'b0;
        valid_in   = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_in = 1'b1;
        #1;
        check("abort_ready_in_reset", {31'd0, ready_out}, 32'd0);
        tick();
        reset_in = 1'b0;
        #1;
        check("abort_valid", {31'd0, valid_out}, 32'd0);
        check("abort_float", floating_out, 32'd0);
        check("abort_inexact", {31'd0, inexact_out}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_out) check("abort_stray_valid", 32'd1, 32'd0);
        end
        convert(32'h0000_0002, 1'b0, f, inx, lat);
        check("abort_fresh_result", f, 32'h4000_0000);
        check("abort_fresh_latency", 32'(lat), 32'd33);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            v = $urandom;
            v = v >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (s && $urandom_range(0, 2) == 0) v = 32'd0 - v;
            model(v, s, ef, einx, elat);
            convert(v, s, f, inx, lat);
            check($sformatf("rand%0d_result v=%h s=%0d", i, v, s), f, ef);
            check($sformatf("rand%0d_inexact", i), {31'd0, inx}, {31'd0, einx});
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
